// File: rtl/br_update_queue_pkg.sv
// Shared definitions for the branch-update queue: dequeue classification of the
// two head entries and the pop count that goes with each class.
package br_update_queue_pkg;

  typedef enum logic [1:0] {
    DEQ_NONE  = 2'd0,
    DEQ_ONE   = 2'd1,
    DEQ_MERGE = 2'd2,
    DEQ_PAIR  = 2'd3
  } deq_kind_e;

  // Bank of an entry is its index LSB; same_bank is the equality of those bits.
  function automatic deq_kind_e deq_classify(input logic h_valid, input logic n_valid,
                                             input logic same_index, input logic same_bank);
    deq_kind_e kind;
    if (!h_valid)        kind = DEQ_NONE;
    else if (!n_valid)   kind = DEQ_ONE;
    else if (same_index) kind = DEQ_MERGE;
    else if (same_bank)  kind = DEQ_ONE;
    else                 kind = DEQ_PAIR;
    return kind;
  endfunction

  function automatic logic [1:0] deq_pops(input deq_kind_e kind);
    logic [1:0] pops;
    case (kind)
      DEQ_ONE:   pops = 2'd1;
      DEQ_MERGE: pops = 2'd2;
      DEQ_PAIR:  pops = 2'd2;
      default:   pops = 2'd0;
    endcase
    return pops;
  endfunction

endpackage

// File: rtl/br_update_queue_chk.sv
// Protocol checker: results must not be offered while the queue is not ready.
module br_update_queue_chk #(
  parameter int IN_WIDTH = 2
) (
  input logic                clk,
  input logic                rst,
  input logic [IN_WIDTH-1:0] in_valid,
  input logic                in_ready
);

  a_no_push_when_not_ready: assert property (@(posedge clk) disable iff (rst)
    !((|in_valid) && !in_ready));

endmodule

// File: rtl/br_update_queue_pht_counter_update.sv
// Saturating update of one counter entry: only counter[hist] moves, up on taken,
// down on not-taken, clamped to [0, CTR_MAX].
module pht_counter_update #(
  parameter int HIST_BITS = 2,
  parameter int CTR_BITS  = 2,
  localparam int CW       = (1 << HIST_BITS) * CTR_BITS
) (
  input  logic [CW-1:0]        ctrs_in,
  input  logic [HIST_BITS-1:0] hist,
  input  logic                 taken,
  output logic [CW-1:0]        ctrs_out
);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};

  logic [CTR_BITS-1:0] ctr_s;
  logic [CTR_BITS-1:0] ctr_next_s;

  // select the addressed counter and saturate it
  always_comb begin
    ctr_s      = ctrs_in[hist*CTR_BITS +: CTR_BITS];
    ctr_next_s = taken ? ((ctr_s == CTR_MAX)  ? ctr_s : ctr_s + CTR_ONE)
                       : ((ctr_s == CTR_ZERO) ? ctr_s : ctr_s - CTR_ONE);
    ctrs_out   = ctrs_in;
    ctrs_out[hist*CTR_BITS +: CTR_BITS] = ctr_next_s;
  end

endmodule

// File: rtl/br_update_queue.sv
// In-order queue of resolved branches feeding the PAs predictor write ports;
// keeps the two counter writes in different banks and merges same-index pairs.
module br_update_queue
  import br_update_queue_pkg::*;
#(
  parameter int ENTRY_NUM  = 8,
  parameter int IN_WIDTH   = 2,
  parameter int INDEX_BITS = 8,
  parameter int HIST_BITS  = 2,
  parameter int CTR_BITS   = 2,
  localparam int CW        = (1 << HIST_BITS) * CTR_BITS,
  localparam int PTR_BITS  = $clog2(ENTRY_NUM),
  localparam int CNT_BITS  = PTR_BITS + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   in_valid,
  input  logic [INDEX_BITS-1:0] in_index [IN_WIDTH],
  input  logic [HIST_BITS-1:0]  in_hist  [IN_WIDTH],
  input  logic [CW-1:0]         in_ctrs  [IN_WIDTH],
  input  logic [IN_WIDTH-1:0]   in_taken,
  input  logic [IN_WIDTH-1:0]   in_mispred,
  input  logic [IN_WIDTH-1:0]   in_cond,
  output logic                  in_ready,
  output logic [1:0]            pht_we,
  output logic [INDEX_BITS-1:0] pht_wa [2],
  output logic [CW-1:0]         pht_wv [2],
  output logic                  hist_we,
  output logic [INDEX_BITS-1:0] hist_wa,
  output logic [HIST_BITS-1:0]  hist_wv,
  output logic [CNT_BITS-1:0]   count
);

  typedef struct packed {
    logic [INDEX_BITS-1:0] index;
    logic [HIST_BITS-1:0]  hist;
    logic [CW-1:0]         ctrs;
    logic                  taken;
    logic                  mispred;
    logic                  cond;
  } entry_t;

  localparam logic [CNT_BITS-1:0] CNT_ZERO  = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_TWO   = CNT_BITS'(2);
  localparam logic [CNT_BITS-1:0] ENTRY_CNT = CNT_BITS'(ENTRY_NUM);
  localparam logic [CNT_BITS-1:0] IN_CNT    = CNT_BITS'(IN_WIDTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);

  entry_t              mem_q [ENTRY_NUM];
  entry_t              mem_d [ENTRY_NUM];
  logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_BITS-1:0] push_cnt_s, pop_cnt_s;
  entry_t              head_s, next_s;
  deq_kind_e           kind_s;
  logic [CW-1:0]       head_upd_s, next_upd_s, merge_upd_s;
  logic                head_rec_s, next_rec_s;

  assign in_ready = (ENTRY_CNT - count_q) >= IN_CNT;
  assign count    = count_q;
  assign head_s   = mem_q[head_q];
  assign next_s   = mem_q[head_q + PTR_ONE];
  assign kind_s   = deq_classify(count_q != CNT_ZERO, count_q >= CNT_TWO,
                                 head_s.index == next_s.index,
                                 head_s.index[0] == next_s.index[0]);
  assign pop_cnt_s = CNT_BITS'(deq_pops(kind_s));

  pht_counter_update #(.HIST_BITS(HIST_BITS), .CTR_BITS(CTR_BITS)) u_head_upd (
    .ctrs_in(head_s.ctrs), .hist(head_s.hist), .taken(head_s.taken), .ctrs_out(head_upd_s)
  );
  pht_counter_update #(.HIST_BITS(HIST_BITS), .CTR_BITS(CTR_BITS)) u_next_upd (
    .ctrs_in(next_s.ctrs), .hist(next_s.hist), .taken(next_s.taken), .ctrs_out(next_upd_s)
  );
  // merge applies the younger update on top of the older one's result
  pht_counter_update #(.HIST_BITS(HIST_BITS), .CTR_BITS(CTR_BITS)) u_merge_upd (
    .ctrs_in(head_upd_s), .hist(next_s.hist), .taken(next_s.taken), .ctrs_out(merge_upd_s)
  );

  // compacting push of valid ports at tail, pointer and occupancy update
  always_comb begin
    mem_d      = mem_q;
    push_cnt_s = CNT_ZERO;
    for (int p = 0; p < IN_WIDTH; p++) begin
      if (in_ready && in_valid[p]) begin
        mem_d[tail_q + push_cnt_s[PTR_BITS-1:0]] = '{index: in_index[p], hist: in_hist[p],
                                                     ctrs: in_ctrs[p], taken: in_taken[p],
                                                     mispred: in_mispred[p], cond: in_cond[p]};
        push_cnt_s = push_cnt_s + CNT_ONE;
      end else begin
        push_cnt_s = push_cnt_s;
      end
    end
    tail_d  = tail_q + push_cnt_s[PTR_BITS-1:0];
    head_d  = head_q + pop_cnt_s[PTR_BITS-1:0];
    count_d = count_q + push_cnt_s - pop_cnt_s;
  end

  // counter-write and history-recovery ports, zero whenever not enabled
  always_comb begin
    pht_we    = 2'b00;
    pht_wa[0] = '0;
    pht_wa[1] = '0;
    pht_wv[0] = '0;
    pht_wv[1] = '0;
    case (kind_s)
      DEQ_ONE: begin
        pht_we[0] = 1'b1;
        pht_wa[0] = head_s.index;
        pht_wv[0] = head_upd_s;
      end
      DEQ_MERGE: begin
        pht_we[0] = 1'b1;
        pht_wa[0] = head_s.index;
        pht_wv[0] = merge_upd_s;
      end
      DEQ_PAIR: begin
        pht_we    = 2'b11;
        pht_wa[0] = head_s.index;
        pht_wv[0] = head_upd_s;
        pht_wa[1] = next_s.index;
        pht_wv[1] = next_upd_s;
      end
      default: pht_we = 2'b00;
    endcase
    head_rec_s = (kind_s != DEQ_NONE) && head_s.mispred && head_s.cond;
    next_rec_s = ((kind_s == DEQ_MERGE) || (kind_s == DEQ_PAIR)) && next_s.mispred && next_s.cond;
    if (next_rec_s) begin
      hist_we = 1'b1;
      hist_wa = next_s.index;
      hist_wv = {next_s.hist[HIST_BITS-2:0], next_s.taken};
    end else if (head_rec_s) begin
      hist_we = 1'b1;
      hist_wa = head_s.index;
      hist_wv = {head_s.hist[HIST_BITS-2:0], head_s.taken};
    end else begin
      hist_we = 1'b0;
      hist_wa = '0;
      hist_wv = '0;
    end
  end

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // entry storage; contents past count are don't-care so it needs no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  br_update_queue_chk #(.IN_WIDTH(IN_WIDTH)) u_chk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready)
  );

endmodule

// File: tb/tb_br_update_queue.sv
// Bench for br_update_queue: a queue-based reference model checks every cycle,
// plus a vector table for counter updates and directed corner sequences.
module tb_br_update_queue;

  localparam int ENTRY_NUM  = 8;
  localparam int IN_WIDTH   = 2;
  localparam int INDEX_BITS = 8;
  localparam int HIST_BITS  = 2;
  localparam int CTR_BITS   = 2;
  localparam int CW         = (1 << HIST_BITS) * CTR_BITS;
  localparam int CNT_BITS   = $clog2(ENTRY_NUM) + 1;
  localparam int CTR_MAX    = (1 << CTR_BITS) - 1;
  localparam int HMASK      = (1 << HIST_BITS) - 1;

  typedef struct {
    int index; int hist; int ctrs; bit taken; bit mispred; bit cond;
  } ent_t;

  typedef struct {
    int index; int hist; int ctrs; bit taken; int exp_ctrs;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [IN_WIDTH-1:0]   in_valid, in_taken, in_mispred, in_cond;
  logic [INDEX_BITS-1:0] in_index [IN_WIDTH];
  logic [HIST_BITS-1:0]  in_hist  [IN_WIDTH];
  logic [CW-1:0]         in_ctrs  [IN_WIDTH];
  logic                  in_ready;
  logic [1:0]            pht_we;
  logic [INDEX_BITS-1:0] pht_wa [2];
  logic [CW-1:0]         pht_wv [2];
  logic                  hist_we;
  logic [INDEX_BITS-1:0] hist_wa;
  logic [HIST_BITS-1:0]  hist_wv;
  logic [CNT_BITS-1:0]   count;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];
  ent_t cur_ent [IN_WIDTH];
  int   exp_pop;
  bit   model_ready;

  br_update_queue #(.ENTRY_NUM(ENTRY_NUM), .IN_WIDTH(IN_WIDTH), .INDEX_BITS(INDEX_BITS),
                    .HIST_BITS(HIST_BITS), .CTR_BITS(CTR_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_index(in_index), .in_hist(in_hist),
    .in_ctrs(in_ctrs), .in_taken(in_taken), .in_mispred(in_mispred), .in_cond(in_cond),
    .in_ready(in_ready), .pht_we(pht_we), .pht_wa(pht_wa), .pht_wv(pht_wv),
    .hist_we(hist_we), .hist_wa(hist_wa), .hist_wv(hist_wv), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // counter[hist] moves one step toward taken/not-taken, clamped to [0, CTR_MAX]
  function automatic int upd(int ctrs, int hist, bit taken);
    int sh = hist * CTR_BITS;
    int c  = (ctrs >> sh) & CTR_MAX;
    if (taken) c = (c < CTR_MAX) ? c + 1 : c;
    else       c = (c > 0) ? c - 1 : 0;
    return (ctrs & ~(CTR_MAX << sh)) | (c << sh);
  endfunction

  task automatic check_outputs();
    int e_we0 = 0, e_wa0 = 0, e_wv0 = 0, e_we1 = 0, e_wa1 = 0, e_wv1 = 0;
    int e_hwe = 0, e_hwa = 0, e_hwv = 0, npop = 0;
    if (mq.size() >= 1) begin
      e_we0 = 1; e_wa0 = mq[0].index; e_wv0 = upd(mq[0].ctrs, mq[0].hist, mq[0].taken);
      npop = 1;
      if (mq.size() >= 2) begin
        if (mq[1].index == mq[0].index) begin
          e_wv0 = upd(e_wv0, mq[1].hist, mq[1].taken);
          npop = 2;
        end else if ((mq[1].index % 2) != (mq[0].index % 2)) begin
          e_we1 = 1; e_wa1 = mq[1].index; e_wv1 = upd(mq[1].ctrs, mq[1].hist, mq[1].taken);
          npop = 2;
        end
      end
      for (int k = 0; k < npop; k++) begin
        if (mq[k].mispred && mq[k].cond) begin
          e_hwe = 1; e_hwa = mq[k].index; e_hwv = ((mq[k].hist << 1) | int'(mq[k].taken)) & HMASK;
        end
      end
    end
    model_ready = (ENTRY_NUM - mq.size()) >= IN_WIDTH;
    exp_pop     = npop;
    chk("count", count, mq.size());
    chk("in_ready", in_ready, int'(model_ready));
    chk("pht_we0", pht_we[0], e_we0);
    chk("pht_wa0", pht_wa[0], e_wa0);
    chk("pht_wv0", pht_wv[0], e_wv0);
    chk("pht_we1", pht_we[1], e_we1);
    chk("pht_wa1", pht_wa[1], e_wa1);
    chk("pht_wv1", pht_wv[1], e_wv1);
    chk("hist_we", hist_we, e_hwe);
    chk("hist_wa", hist_wa, e_hwa);
    chk("hist_wv", hist_wv, e_hwv);
  endtask

  task automatic drive(int p, ent_t e, bit v);
    cur_ent[p]    = e;
    in_valid[p]   = v;
    in_index[p]   = INDEX_BITS'(e.index);
    in_hist[p]    = HIST_BITS'(e.hist);
    in_ctrs[p]    = CW'(e.ctrs);
    in_taken[p]   = e.taken;
    in_mispred[p] = e.mispred;
    in_cond[p]    = e.cond;
  endtask

  task automatic idle();
    ent_t z = '{index: 0, hist: 0, ctrs: 0, taken: 0, mispred: 0, cond: 0};
    for (int p = 0; p < IN_WIDTH; p++) drive(p, z, 1'b0);
  endtask

  // check at the negedge, advance one edge, then update the model
  task automatic cycle();
    bit rdy;
    check_outputs();
    rdy = model_ready;
    @(posedge clk);
    for (int k = 0; k < exp_pop; k++) void'(mq.pop_front());
    for (int p = 0; p < IN_WIDTH; p++)
      if (rdy && in_valid[p]) mq.push_back(cur_ent[p]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.index   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
    e.hist    = $urandom_range(0, HMASK);
    e.ctrs    = $urandom_range(0, (1 << CW) - 1);
    e.taken   = 1'($urandom_range(0, 1));
    e.mispred = 1'($urandom_range(0, 1));
    e.cond    = 1'($urandom_range(0, 1));
    return e;
  endfunction

  function automatic ent_t mk(int index, int hist, int ctrs, bit taken, bit mispred, bit cond);
    ent_t e = '{index: index, hist: hist, ctrs: ctrs, taken: taken, mispred: mispred, cond: cond};
    return e;
  endfunction

  initial begin
    vec_t vt [6];
    int   nxt;
    bit   saw_full;
    vt[0] = '{index: 'h10, hist: 1, ctrs: 'h55, taken: 1'b1, exp_ctrs: 'h59};
    vt[1] = '{index: 'h31, hist: 3, ctrs: 'hE4, taken: 1'b1, exp_ctrs: 'hE4};
    vt[2] = '{index: 'h44, hist: 0, ctrs: 'hE4, taken: 1'b0, exp_ctrs: 'hE4};
    vt[3] = '{index: 'h07, hist: 2, ctrs: 'hE4, taken: 1'b0, exp_ctrs: 'hD4};
    vt[4] = '{index: 'h8A, hist: 1, ctrs: 'h00, taken: 1'b1, exp_ctrs: 'h04};
    vt[5] = '{index: 'hFF, hist: 3, ctrs: 'hFF, taken: 1'b0, exp_ctrs: 'hBF};

    idle();
    do_reset();
    check_outputs();

    // single results: written one cycle after acceptance
    for (int i = 0; i < 6; i++) begin
      drive(0, mk(vt[i].index, vt[i].hist, vt[i].ctrs, vt[i].taken, 1'b0, 1'b1), 1'b1);
      cycle();
      idle();
      chk("tbl_we0", pht_we[0], 1);
      chk("tbl_wa0", pht_wa[0], vt[i].index);
      chk("tbl_wv0", pht_wv[0], vt[i].exp_ctrs);
      chk("tbl_we1", pht_we[1], 0);
      cycle();
    end

    // same-index pair merges into one write
    drive(0, mk('h20, 0, 'h55, 1'b1, 1'b0, 1'b1), 1'b1);
    drive(1, mk('h20, 0, 'h55, 1'b1, 1'b0, 1'b1), 1'b1);
    cycle();
    idle();
    chk("merge_we0", pht_we[0], 1);
    chk("merge_wv0", pht_wv[0], 'h57);
    chk("merge_we1", pht_we[1], 0);
    cycle();
    chk("merge_count", count, 0);

    // bank conflict serialises the pair
    drive(0, mk('h02, 1, 'h55, 1'b1, 1'b0, 1'b1), 1'b1);
    drive(1, mk('h04, 2, 'h55, 1'b0, 1'b0, 1'b1), 1'b1);
    cycle();
    idle();
    chk("conf_wa0_first", pht_wa[0], 'h02);
    chk("conf_we1_first", pht_we[1], 0);
    cycle();
    chk("conf_wa0_second", pht_wa[0], 'h04);
    chk("conf_we0_second", pht_we[0], 1);
    cycle();

    // fill with same-bank stream, one pop per cycle, across pointer wrap
    nxt = 2;
    saw_full = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if ((ENTRY_NUM - mq.size()) >= IN_WIDTH) begin
        drive(0, mk(nxt, c % 4, 'h1B, 1'b1, 1'b0, 1'b0), 1'b1);
        drive(1, mk(nxt + 2, (c + 1) % 4, 'hC6, 1'b0, 1'b0, 1'b0), 1'b1);
        nxt += 4;
      end else begin
        idle();
      end
      if (mq.size() == ENTRY_NUM - 1) begin
        chk("full_not_ready", in_ready, 0);
        saw_full = 1'b1;
      end
      if (saw_full && mq.size() == ENTRY_NUM - 2) chk("full_ready_again", in_ready, 1);
      cycle();
    end
    idle();
    repeat (ENTRY_NUM + 2) cycle();

    // history recovery
    drive(0, mk('h33, 1, 'h55, 1'b1, 1'b1, 1'b1), 1'b1);
    cycle();
    idle();
    chk("rec_we", hist_we, 1);
    chk("rec_wa", hist_wa, 'h33);
    chk("rec_wv", hist_wv, 3);
    cycle();
    drive(0, mk('h11, 1, 'h55, 1'b1, 1'b1, 1'b1), 1'b1);
    drive(1, mk('h12, 2, 'h55, 1'b1, 1'b1, 1'b1), 1'b1);
    cycle();
    idle();
    chk("rec_young_wa", hist_wa, 'h12);
    chk("rec_young_wv", hist_wv, 1);
    cycle();
    drive(0, mk('h40, 1, 'h55, 1'b1, 1'b1, 1'b0), 1'b1);
    cycle();
    idle();
    cycle();

    // reset with five entries queued
    for (int c = 0; c < 4; c++) begin
      drive(0, mk('h50 + 4 * c, 0, 'h55, 1'b1, 1'b0, 1'b1), 1'b1);
      drive(1, mk('h52 + 4 * c, 1, 'h55, 1'b0, 1'b0, 1'b1), 1'b1);
      cycle();
    end
    idle();
    chk("rst_pre_count", count, 5);
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_we", pht_we, 0);
    chk("rst_ready", in_ready, 1);
    check_outputs();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle();
        check_outputs();
        do_reset();
      end else begin
        for (int p = 0; p < IN_WIDTH; p++)
          drive(p, rand_ent(),
                ((ENTRY_NUM - mq.size()) >= IN_WIDTH) && ($urandom_range(0, 3) != 0));
        cycle();
      end
    end
    idle();
    repeat (ENTRY_NUM + 2) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
